// File: rtl/scoreboard_sched_pkg.sv
// Shared types for the lane-scheduling scoreboard controller.
package scoreboard_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET_SB = 3'd0,
    ST_ARMED    = 3'd1,
    ST_TRACK    = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } sched_state_e;

endpackage

// File: rtl/lane_rr_ptr.sv
// Round-robin lane pointer: advances by one on adv, wraps from LANES-1 to 0.
module lane_rr_ptr #(
  parameter int LANES = 4,
  parameter int LANEW = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [LANEW-1:0] ptr
);

  logic [LANEW-1:0] ptr_q;
  logic [LANEW-1:0] ptr_d;

  // Next pointer: explicit wrap so non-power-of-two lane counts work.
  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (ptr_q == LANEW'(LANES - 1)) ? '0 : ptr_q + LANEW'(1);
    end
  end

  // Pointer register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/scoreboard_lane_sched.sv
// Time-shares one magic-packet scoreboard across several FIFO lanes,
// re-arming it between checks and bounding each check with a timeout.
module scoreboard_lane_sched
  import scoreboard_sched_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64,
  parameter int LANEW   = $clog2(LANES),
  parameter int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LANES-1:0]       lane_push,
  input  logic [LANES-1:0]       lane_pop,
  input  logic [LANES*WIDTH-1:0] lane_data_in,
  input  logic [LANES*WIDTH-1:0] lane_data_out,
  input  logic                   start_req,
  output logic                   sb_rst,
  output logic                   sb_push,
  output logic                   sb_pop,
  output logic                   sb_start,
  output logic [WIDTH-1:0]       sb_data_in,
  output logic [WIDTH-1:0]       sb_data_out,
  input  logic                   sb_data_out_vld,
  input  logic                   sb_prop,
  output logic [LANEW-1:0]       lane_sel,
  output logic                   busy,
  output logic                   check_done,
  output logic                   timeout_err,
  output logic                   prop_ok
);

  sched_state_e  state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] din_arr  [LANES];
  logic [WIDTH-1:0] dout_arr [LANES];

  // Unpack the flat lane buses so the selected lane is a plain array index.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_unpack
      assign din_arr[gi]  = lane_data_in[gi*WIDTH +: WIDTH];
      assign dout_arr[gi] = lane_data_out[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Lane only moves on DONE->RESET_SB, so it is stable while a packet is held.
  lane_rr_ptr #(
    .LANES (LANES),
    .LANEW (LANEW)
  ) u_ptr (
    .clk (clk),
    .rst (rst),
    .adv (state_q == ST_DONE),
    .ptr (lane_sel)
  );

  // Next-state and timeout counter; exit indication beats the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RESET_SB: begin
        state_d = ST_ARMED;
        cnt_d   = '0;
      end
      ST_ARMED: begin
        if (start_req && lane_push[lane_sel]) begin
          state_d = ST_TRACK;
          cnt_d   = '0;
        end
      end
      ST_TRACK: begin
        if (cnt_q != TW'(TIMEOUT)) cnt_d = cnt_q + TW'(1);
        if (sb_data_out_vld)                state_d = ST_DONE;
        else if (cnt_q == TW'(TIMEOUT - 1)) state_d = ST_ERR;
      end
      ST_DONE:  state_d = ST_RESET_SB;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_RESET_SB;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET_SB;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Routing and status; the scoreboard sees nothing while it is being reset.
  always_comb begin
    sb_rst      = rst | (state_q == ST_RESET_SB);
    sb_push     = 1'b0;
    sb_pop      = 1'b0;
    sb_start    = 1'b0;
    busy        = (state_q == ST_ARMED) || (state_q == ST_TRACK);
    check_done  = (state_q == ST_DONE);
    timeout_err = (state_q == ST_ERR);
    if (state_q != ST_RESET_SB) begin
      sb_push = lane_push[lane_sel];
      sb_pop  = lane_pop[lane_sel];
    end
    if (state_q == ST_ARMED) sb_start = start_req;
    prop_ok = sb_prop & ~timeout_err;
  end

  assign sb_data_in  = din_arr[lane_sel];
  assign sb_data_out = dout_arr[lane_sel];

endmodule

// File: tb/tb_scoreboard_lane_sched.sv
// Directed bench for scoreboard_lane_sched (LANES=4, WIDTH=8, TIMEOUT=8).
module tb_scoreboard_lane_sched;

  localparam int LANES   = 4;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 8;
  localparam int LANEW   = $clog2(LANES);

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES-1:0]       lane_push;
  logic [LANES-1:0]       lane_pop;
  logic [LANES*WIDTH-1:0] lane_data_in;
  logic [LANES*WIDTH-1:0] lane_data_out;
  logic                   start_req;
  logic                   sb_rst, sb_push, sb_pop, sb_start;
  logic [WIDTH-1:0]       sb_data_in, sb_data_out;
  logic                   sb_data_out_vld;
  logic                   sb_prop;
  logic [LANEW-1:0]       lane_sel;
  logic                   busy, check_done, timeout_err, prop_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scoreboard_lane_sched #(
    .LANES   (LANES),
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lane_push       (lane_push),
    .lane_pop        (lane_pop),
    .lane_data_in    (lane_data_in),
    .lane_data_out   (lane_data_out),
    .start_req       (start_req),
    .sb_rst          (sb_rst),
    .sb_push         (sb_push),
    .sb_pop          (sb_pop),
    .sb_start        (sb_start),
    .sb_data_in      (sb_data_in),
    .sb_data_out     (sb_data_out),
    .sb_data_out_vld (sb_data_out_vld),
    .sb_prop         (sb_prop),
    .lane_sel        (lane_sel),
    .busy            (busy),
    .check_done      (check_done),
    .timeout_err     (timeout_err),
    .prop_ok         (prop_ok)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Move to the middle of the next cycle (away from the rising edge).
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Capture on the given lane from ARMED; returns in cycle t+1 (TRACK).
  task automatic capture(input int lane);
    logic [WIDTH-1:0] din, dout;
    din  = WIDTH'(8'h10 + lane);
    dout = WIDTH'(8'h20 + lane);
    chk("cap_lane_sel", lane_sel, lane);
    start_req = 1'b1;
    lane_push = '0;
    lane_push[lane] = 1'b1;
    lane_data_in[lane*WIDTH +: WIDTH]  = din;
    lane_data_out[lane*WIDTH +: WIDTH] = dout;
    #1;
    chk("cap_sb_start", sb_start, 1);
    chk("cap_sb_push", sb_push, 1);
    chk("cap_sb_data_in", sb_data_in, din);
    chk("cap_sb_data_out", sb_data_out, dout);
    tick();
    lane_push = '0;
    #1;
    chk("track_busy", busy, 1);
    chk("track_no_start", sb_start, 0);
    start_req = 1'b0;
  endtask

  // Full check with exit indication `dwell` cycles after capture.
  task automatic run_check(input int lane, input int dwell);
    capture(lane);
    repeat (dwell - 1) tick();
    sb_data_out_vld = 1'b1;
    tick();
    sb_data_out_vld = 1'b0;
    #1;
    chk("done_pulse", check_done, 1);
    chk("done_not_busy", busy, 0);
    chk("done_lane_hold", lane_sel, lane);
    tick();
    chk("rsb_done_low", check_done, 0);
    chk("rsb_sb_rst", sb_rst, 1);
    chk("rsb_lane_next", lane_sel, (lane + 1) % LANES);
    tick();
    chk("armed_sb_rst", sb_rst, 0);
    chk("armed_busy", busy, 1);
  endtask

  initial begin
    rst = 1'b1;
    lane_push = '0;
    lane_pop = '0;
    lane_data_in = '0;
    lane_data_out = '0;
    start_req = 1'b0;
    sb_data_out_vld = 1'b0;
    sb_prop = 1'b1;

    // Reset state.
    tick();
    tick();
    chk("rst_sb_rst", sb_rst, 1);
    chk("rst_lane_sel", lane_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_check_done", check_done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    #1;
    chk("cyc1_sb_rst", sb_rst, 1);
    chk("cyc1_busy", busy, 0);
    lane_push = 4'b1111;
    #1;
    chk("cyc1_no_push", sb_push, 0);
    lane_push = '0;

    // Idle in ARMED with no request.
    tick();
    chk("idle_sb_rst", sb_rst, 0);
    chk("idle_busy", busy, 1);
    chk("idle_lane_sel", lane_sel, 0);
    repeat (3) begin
      tick();
      chk("idle_no_done", check_done, 0);
    end

    // Lane 0 check, exit 5 cycles after capture; then lanes 1..3 and wrap.
    run_check(0, 5);
    run_check(1, 2);
    run_check(2, 1);
    run_check(3, 3);
    chk("wrap_lane_sel", lane_sel, 0);

    // Pushes/requests that must not capture.
    run_check(0, 1);
    start_req = 1'b1;
    lane_push = 4'b1101;
    lane_pop  = 4'b0010;
    #1;
    chk("unsel_push", sb_push, 0);
    chk("sel_pop", sb_pop, 1);
    tick();
    lane_push = '0;
    lane_pop  = '0;
    #1;
    chk("unsel_still_armed", sb_start, 1);
    start_req = 1'b0;
    lane_push = 4'b0010;
    tick();
    lane_push = '0;
    start_req = 1'b1;
    #1;
    chk("push_no_req_armed", sb_start, 1);
    start_req = 1'b0;

    // Exit coincident with counter == TIMEOUT-1 on lane 1.
    capture(1);
    repeat (7) tick();
    chk("coin_pre_err", timeout_err, 0);
    sb_data_out_vld = 1'b1;
    tick();
    sb_data_out_vld = 1'b0;
    #1;
    chk("coin_done", check_done, 1);
    chk("coin_no_err", timeout_err, 0);
    tick();
    chk("coin_lane_next", lane_sel, 2);
    tick();

    // Timeout on lane 2 with no exit.
    capture(2);
    repeat (7) tick();
    chk("to_pre_err", timeout_err, 0);
    chk("to_pre_prop_ok", prop_ok, 1);
    tick();
    chk("to_err", timeout_err, 1);
    chk("to_prop_ok", prop_ok, 0);
    chk("to_busy", busy, 0);
    lane_push = 4'b0100;
    sb_data_out_vld = 1'b1;
    #1;
    chk("err_routing_live", sb_push, 1);
    tick();
    lane_push = '0;
    sb_data_out_vld = 1'b0;
    repeat (4) tick();
    chk("err_sticky", timeout_err, 1);
    chk("err_no_done", check_done, 0);
    chk("err_lane_hold", lane_sel, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("err_rst_clear", timeout_err, 0);
    chk("err_rst_prop_ok", prop_ok, 1);
    chk("err_rst_lane", lane_sel, 0);
    tick();

    // Reset in the middle of a lane-2 check.
    run_check(0, 1);
    run_check(1, 1);
    capture(2);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_sb_rst", sb_rst, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_lane_sel", lane_sel, 0);
    chk("mid_sb_rst", sb_rst, 1);
    chk("mid_no_done", check_done, 0);
    chk("mid_busy", busy, 0);
    tick();
    chk("mid_armed", busy, 1);
    chk("mid_armed_sb_rst", sb_rst, 0);
    repeat (3) begin
      tick();
      chk("mid_never_done", check_done, 0);
    end
    // Fresh check after reset runs to the boundary without timing out.
    capture(0);
    repeat (7) tick();
    chk("post_rst_no_err", timeout_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
